// File: rtl/ir_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ir_seq_pkg
// Purpose  : Shared definitions for the impulse-response capture sequencer.
//            Holds the state encoding, the default parameter constants and
//            the saturating-magnitude helper used by the quiet detector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ir_seq_pkg;

    // State encoding; the numeric codes are visible on state_out.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_ARM    = 3'd1;
    localparam state_t ST_PING   = 3'd2;
    localparam state_t ST_WAIT   = 3'd3;
    localparam state_t ST_RECORD = 3'd4;
    localparam state_t ST_READY  = 3'd5;
    localparam state_t ST_FAULT  = 3'd6;

    // Default parameter values (sample counts are at the 24 kHz trigger rate).
    localparam logic        [15:0] DEF_PING_LEN      = 16'd8;
    localparam logic signed [15:0] DEF_PING_AMP      = 16'sh4000;
    localparam logic        [15:0] DEF_QUIET_THRESH  = 16'd512;
    localparam logic        [15:0] DEF_QUIET_SAMPLES = 16'd2400;
    localparam logic        [15:0] DEF_ARM_TIMEOUT   = 16'd24000;
    localparam logic        [15:0] DEF_REC_TIMEOUT   = 16'd48000;

    // |s| for a 16-bit two's complement sample. -32768 has no positive
    // counterpart, so it saturates to 32767 instead of wrapping to itself.
    function automatic logic [15:0] sat_mag(input logic signed [15:0] s);
        logic [15:0] r;
        if (s == 16'sh8000) begin
            r = 16'h7FFF;
        end else if (s[15]) begin
            r = ~s + 16'd1;
        end else begin
            r = s;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quiet_detector.sv
`default_nettype none
// ============================================================================
// Module   : quiet_detector
// Purpose  : Counts consecutive quiet microphone samples. A sample is quiet
//            when its saturated magnitude is below QUIET_THRESH; any loud
//            sample restarts the run. armed_o flags the sample that
//            completes a run of QUIET_SAMPLES quiet samples.
// Ports    : clk_i     - clock
//            rst_i     - synchronous active-high reset
//            clear_i   - forces the run count back to zero
//            en_i      - a new sample is present this cycle
//            sample_i  - signed microphone sample
//            armed_o   - combinational: this sample completes the quiet run
// Revision : 1.0 - initial release
// ============================================================================
module quiet_detector
    import ir_seq_pkg::*;
#(
    parameter logic [15:0] QUIET_THRESH  = DEF_QUIET_THRESH,
    parameter logic [15:0] QUIET_SAMPLES = DEF_QUIET_SAMPLES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               en_i,
    input  logic signed [15:0] sample_i,
    output logic               armed_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;
    logic [15:0] w_mag;
    logic        w_quiet;
    logic [16:0] w_count_inc;

    assign w_mag       = sat_mag(sample_i);
    assign w_quiet     = (w_mag < QUIET_THRESH);
    // One bit wider so the compare cannot wrap at the top of the range.
    assign w_count_inc = {1'b0, count_q} + 17'd1;

    assign armed_o = en_i && w_quiet && (w_count_inc >= {1'b0, QUIET_SAMPLES});

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 16'd0;
        end else if (en_i) begin
            if (!w_quiet) begin
                count_d = 16'd0;
            end else if (count_q != 16'hFFFF) begin
                count_d = w_count_inc[15:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ir_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ir_capture_sequencer
// Purpose  : Sequences one impulse-response capture: wait for a quiet room,
//            play a short rectangular ping, wait a programmable delay, start
//            the recorder, then hand off to the convolution stage. Sample
//            counters only advance on audio_trigger strobes.
// Ports    : audio_clk        - sole clock
//            rst_in           - synchronous active-high reset
//            audio_trigger    - one-cycle strobe per 24 kHz sample
//            start_in         - one-cycle pulse, begins / restarts a capture
//            abort_in         - one-cycle pulse, returns to IDLE (wins over start)
//            audio_in         - signed microphone sample
//            delay_length     - samples from ping end to record start
//            record_done_in   - recorder-complete level
//            ping_out         - signed speaker drive
//            record_start_out - one-cycle pulse on entry to RECORD
//            conv_enable_out  - high in READY
//            busy_out         - high in ARM, PING, WAIT, RECORD
//            fault_out        - high in FAULT
//            state_out        - current state code
// Revision : 1.0 - initial release
// ============================================================================
module ir_capture_sequencer
    import ir_seq_pkg::*;
#(
    parameter logic        [15:0] PING_LEN      = DEF_PING_LEN,
    parameter logic signed [15:0] PING_AMP      = DEF_PING_AMP,
    parameter logic        [15:0] QUIET_THRESH  = DEF_QUIET_THRESH,
    parameter logic        [15:0] QUIET_SAMPLES = DEF_QUIET_SAMPLES,
    parameter logic        [15:0] ARM_TIMEOUT   = DEF_ARM_TIMEOUT,
    parameter logic        [15:0] REC_TIMEOUT   = DEF_REC_TIMEOUT
) (
    input  logic               audio_clk,
    input  logic               rst_in,
    input  logic               audio_trigger,
    input  logic               start_in,
    input  logic               abort_in,
    input  logic signed [15:0] audio_in,
    input  logic        [7:0]  delay_length,
    input  logic               record_done_in,
    output logic signed [15:0] ping_out,
    output logic               record_start_out,
    output logic               conv_enable_out,
    output logic               busy_out,
    output logic               fault_out,
    output logic        [2:0]  state_out
);

    state_t             state_q;
    state_t             state_d;
    logic        [15:0] cnt_q;
    logic        [15:0] cnt_d;
    logic signed [15:0] ping_q;
    logic               rec_start_q;
    logic               conv_q;
    logic               busy_q;
    logic               fault_q;

    logic        [16:0] w_cnt_inc;
    logic               w_armed;
    logic               w_counting;
    logic               w_busy_d;

    // ------------------------------------------------------------------
    // Quiet-room detection (only meaningful while in ARM)
    // ------------------------------------------------------------------
    quiet_detector #(
        .QUIET_THRESH  (QUIET_THRESH),
        .QUIET_SAMPLES (QUIET_SAMPLES)
    ) u_quiet (
        .clk_i    (audio_clk),
        .rst_i    (rst_in),
        .clear_i  (state_q != ST_ARM),
        .en_i     (audio_trigger && (state_q == ST_ARM)),
        .sample_i (audio_in),
        .armed_o  (w_armed)
    );

    // Widened so threshold compares stay correct near 16'hFFFF.
    assign w_cnt_inc = {1'b0, cnt_q} + 17'd1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // Arming wins if quiet completes on the timeout trigger.
                if (audio_trigger) begin
                    if (w_armed) begin
                        state_d = ST_PING;
                    end else if (w_cnt_inc >= {1'b0, ARM_TIMEOUT}) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_PING: begin
                if (audio_trigger && (w_cnt_inc >= {1'b0, PING_LEN})) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // cnt_q holds triggers already seen in WAIT, so a delay of 0
                // leaves on the first trigger.
                if (audio_trigger && (cnt_q >= {8'd0, delay_length})) begin
                    state_d = ST_RECORD;
                end
            end
            ST_RECORD: begin
                // The start pulse is high during the first RECORD cycle;
                // a done level seen alongside it is stale and is ignored.
                if (record_done_in && !rec_start_q) begin
                    state_d = ST_READY;
                end else if (audio_trigger && (w_cnt_inc >= {1'b0, REC_TIMEOUT})) begin
                    state_d = ST_FAULT;
                end
            end
            ST_READY, ST_FAULT: begin
                if (start_in) begin
                    state_d = ST_ARM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_in) begin
            state_d = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Shared sample counter: restarts on every state change, otherwise
    // counts triggers in the timed states.
    // ------------------------------------------------------------------
    assign w_counting = (state_q == ST_ARM)  || (state_q == ST_PING) ||
                        (state_q == ST_WAIT) || (state_q == ST_RECORD);

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = 16'd0;
        end else if (audio_trigger && w_counting) begin
            cnt_d = w_cnt_inc[15:0];
        end
    end

    assign w_busy_d = (state_d == ST_ARM)  || (state_d == ST_PING) ||
                      (state_d == ST_WAIT) || (state_d == ST_RECORD);

    // ------------------------------------------------------------------
    // State, counter and registered outputs. Outputs are decoded from the
    // next state so they change on the same edge as the state register.
    // ------------------------------------------------------------------
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            ping_q      <= 16'sd0;
            rec_start_q <= 1'b0;
            conv_q      <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ping_q      <= (state_d == ST_PING) ? PING_AMP : 16'sd0;
            rec_start_q <= (state_d == ST_RECORD) && (state_q != ST_RECORD);
            conv_q      <= (state_d == ST_READY);
            busy_q      <= w_busy_d;
            fault_q     <= (state_d == ST_FAULT);
        end
    end

    assign ping_out         = ping_q;
    assign record_start_out = rec_start_q;
    assign conv_enable_out  = conv_q;
    assign busy_out         = busy_q;
    assign fault_out        = fault_q;
    assign state_out        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_capture_sequencer
// Purpose  : Self-checking bench for ir_capture_sequencer with default
//            parameters. Table of {inputs, cycle count, expected outputs}
//            rows plus hand-written reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_capture_sequencer;

    localparam logic [15:0] AMP = 16'h4000;

    logic               audio_clk = 1'b0;
    logic               rst_in;
    logic               audio_trigger;
    logic               start_in;
    logic               abort_in;
    logic signed [15:0] audio_in;
    logic        [7:0]  delay_length;
    logic               record_done_in;
    logic signed [15:0] ping_out;
    logic               record_start_out;
    logic               conv_enable_out;
    logic               busy_out;
    logic               fault_out;
    logic        [2:0]  state_out;

    always #5 audio_clk = ~audio_clk;

    ir_capture_sequencer dut (
        .audio_clk        (audio_clk),
        .rst_in           (rst_in),
        .audio_trigger    (audio_trigger),
        .start_in         (start_in),
        .abort_in         (abort_in),
        .audio_in         (audio_in),
        .delay_length     (delay_length),
        .record_done_in   (record_done_in),
        .ping_out         (ping_out),
        .record_start_out (record_start_out),
        .conv_enable_out  (conv_enable_out),
        .busy_out         (busy_out),
        .fault_out        (fault_out),
        .state_out        (state_out)
    );

    typedef struct {
        string       name;
        logic        st;
        logic        ab;
        logic        tr;
        logic [15:0] au;
        logic [7:0]  dl;
        logic        dn;
        int          n;
        logic [2:0]  es;
        logic [15:0] ep;
        logic        ers;
        logic        econv;
        logic        ebusy;
        logic        efault;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;
    int   rs_pulses = 0;

    // Total record_start cycles seen, to catch spurious pulses between checks.
    always @(posedge audio_clk) begin
        if (record_start_out) rs_pulses <= rs_pulses + 1;
    end

    function automatic void add(string nm, logic st, logic ab, logic tr,
                                logic [15:0] au, logic [7:0] dl, logic dn, int n,
                                logic [2:0] es, logic [15:0] ep, logic ers,
                                logic ec, logic eb, logic ef);
        vec_t v;
        v.name = nm; v.st = st; v.ab = ab; v.tr = tr; v.au = au; v.dl = dl;
        v.dn = dn; v.n = n; v.es = es; v.ep = ep; v.ers = ers;
        v.econv = ec; v.ebusy = eb; v.efault = ef;
        vq.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [2:0] es, input logic [15:0] ep,
                         input logic ers, input logic ec, input logic eb, input logic ef);
        tests++;
        if ({state_out, ping_out, record_start_out, conv_enable_out, busy_out, fault_out}
            !== {es, ep, ers, ec, eb, ef}) begin
            fails++;
            $display("FAIL %s: got st=%0d ping=%h rs=%b conv=%b busy=%b flt=%b, expected st=%0d ping=%h rs=%b conv=%b busy=%b flt=%b",
                     nm, state_out, ping_out, record_start_out, conv_enable_out, busy_out, fault_out,
                     es, ep, ers, ec, eb, ef);
        end
    endtask

    task automatic apply(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            start_in       = (i == 0) ? v.st : 1'b0;
            abort_in       = (i == 0) ? v.ab : 1'b0;
            audio_trigger  = v.tr;
            audio_in       = v.au;
            delay_length   = v.dl;
            record_done_in = v.dn;
            @(posedge audio_clk);
            #1;
        end
        start_in = 1'b0;
        abort_in = 1'b0;
        check(v.name, v.es, v.ep, v.ers, v.econv, v.ebusy, v.efault);
    endtask

    initial begin
        // name                 st ab tr au        dl dn n      st ping rs cv by ft
        // A: full capture, delay 2, done 10 triggers into RECORD, restart, abort
        add("a_idle_hold",       0, 0, 1, 16'h0000, 2, 0, 3,     0, 0,   0, 0, 0, 0);
        add("a_start",           1, 0, 1, 16'h0000, 2, 0, 1,     1, 0,   0, 0, 1, 0);
        add("a_arm_2399",        0, 0, 1, 16'h0000, 2, 0, 2399,  1, 0,   0, 0, 1, 0);
        add("a_arm_2400",        0, 0, 1, 16'h0000, 2, 0, 1,     2, AMP, 0, 0, 1, 0);
        add("a_ping_start_ign",  1, 0, 1, 16'h0000, 2, 0, 1,     2, AMP, 0, 0, 1, 0);
        add("a_ping_7",          0, 0, 1, 16'h0000, 2, 0, 6,     2, AMP, 0, 0, 1, 0);
        add("a_ping_end",        0, 0, 1, 16'h0000, 2, 0, 1,     3, 0,   0, 0, 1, 0);
        add("a_wait_2",          0, 0, 1, 16'h0000, 2, 0, 2,     3, 0,   0, 0, 1, 0);
        add("a_rec_entry",       0, 0, 1, 16'h0000, 2, 0, 1,     4, 0,   1, 0, 1, 0);
        add("a_rec_pulse_end",   0, 0, 1, 16'h0000, 2, 0, 1,     4, 0,   0, 0, 1, 0);
        add("a_rec_hold",        0, 0, 1, 16'h0000, 2, 0, 8,     4, 0,   0, 0, 1, 0);
        add("a_rec_done",        0, 0, 1, 16'h0000, 2, 1, 1,     5, 0,   0, 1, 0, 0);
        add("a_ready_hold",      0, 0, 1, 16'h0000, 2, 0, 3,     5, 0,   0, 1, 0, 0);
        add("a_restart",         1, 0, 1, 16'h0000, 2, 0, 1,     1, 0,   0, 0, 1, 0);
        add("a_abort",           0, 1, 1, 16'h0000, 2, 0, 1,     0, 0,   0, 0, 0, 0);
        // B: -32768 never quiet -> FAULT after 24000 triggers
        add("b_start",           1, 0, 1, 16'h8000, 2, 0, 1,     1, 0,   0, 0, 1, 0);
        add("b_arm_23999",       0, 0, 1, 16'h8000, 2, 0, 23999, 1, 0,   0, 0, 1, 0);
        add("b_timeout",         0, 0, 1, 16'h8000, 2, 0, 1,     6, 0,   0, 0, 0, 1);
        add("b_fault_hold",      0, 0, 1, 16'h8000, 2, 0, 5,     6, 0,   0, 0, 0, 1);
        add("b_restart",         1, 0, 1, 16'h0000, 2, 0, 1,     1, 0,   0, 0, 1, 0);
        add("b_abort",           0, 1, 1, 16'h0000, 2, 0, 1,     0, 0,   0, 0, 0, 0);
        // C: delay 0, triggers withheld mid-PING must not advance it
        add("c_start",           1, 0, 1, 16'h0000, 0, 0, 1,     1, 0,   0, 0, 1, 0);
        add("c_arm_2400",        0, 0, 1, 16'h0000, 0, 0, 2400,  2, AMP, 0, 0, 1, 0);
        add("c_ping_7",          0, 0, 1, 16'h0000, 0, 0, 7,     2, AMP, 0, 0, 1, 0);
        add("c_no_trigger",      0, 0, 0, 16'h0000, 0, 0, 20,    2, AMP, 0, 0, 1, 0);
        add("c_ping_end",        0, 0, 1, 16'h0000, 0, 0, 1,     3, 0,   0, 0, 1, 0);
        add("c_rec_entry_d0",    0, 0, 1, 16'h0000, 0, 0, 1,     4, 0,   1, 0, 1, 0);
        add("c_rec_pulse_end",   0, 0, 1, 16'h0000, 0, 0, 1,     4, 0,   0, 0, 1, 0);
        add("c_abort",           0, 1, 1, 16'h0000, 0, 0, 1,     0, 0,   0, 0, 0, 0);
        // D: delay 4 -> RECORD on fifth trigger after ping end; abort+start in RECORD
        add("d_start",           1, 0, 1, 16'h0000, 4, 0, 1,     1, 0,   0, 0, 1, 0);
        add("d_arm_2400",        0, 0, 1, 16'h0000, 4, 0, 2400,  2, AMP, 0, 0, 1, 0);
        add("d_ping_8",          0, 0, 1, 16'h0000, 4, 0, 8,     3, 0,   0, 0, 1, 0);
        add("d_wait_4",          0, 0, 1, 16'h0000, 4, 0, 4,     3, 0,   0, 0, 1, 0);
        add("d_rec_entry_d4",    0, 0, 1, 16'h0000, 4, 0, 1,     4, 0,   1, 0, 1, 0);
        add("d_abort_start_rec", 1, 1, 1, 16'h0000, 4, 0, 1,     0, 0,   0, 0, 0, 0);
        // E: loud sample at 2400th position restarts the quiet run
        add("e_start",           1, 0, 1, 16'h0000, 2, 0, 1,     1, 0,   0, 0, 1, 0);
        add("e_quiet_2399",      0, 0, 1, 16'h0000, 2, 0, 2399,  1, 0,   0, 0, 1, 0);
        add("e_loud_600",        0, 0, 1, 16'd600,  2, 0, 1,     1, 0,   0, 0, 1, 0);
        add("e_quiet_2399b",     0, 0, 1, 16'h0000, 2, 0, 2399,  1, 0,   0, 0, 1, 0);
        add("e_quiet_2400b",     0, 0, 1, 16'h0000, 2, 0, 1,     2, AMP, 0, 0, 1, 0);
        add("e_abort_start_ping",1, 1, 1, 16'h0000, 2, 0, 1,     0, 0,   0, 0, 0, 0);
        add("e_idle_after",      0, 0, 1, 16'h0000, 2, 0, 12,    0, 0,   0, 0, 0, 0);
        // F: threshold boundary: 512 is loud, +/-511 quiet
        add("f_start",           1, 0, 1, 16'h0000, 2, 0, 1,     1, 0,   0, 0, 1, 0);
        add("f_quiet_511",       0, 0, 1, 16'd511,  2, 0, 2399,  1, 0,   0, 0, 1, 0);
        add("f_loud_512",        0, 0, 1, 16'd512,  2, 0, 1,     1, 0,   0, 0, 1, 0);
        add("f_quiet_m511",      0, 0, 1, 16'hFE01, 2, 0, 2399,  1, 0,   0, 0, 1, 0);
        add("f_arm_m511",        0, 0, 1, 16'hFE01, 2, 0, 1,     2, AMP, 0, 0, 1, 0);

        rst_in         = 1'b1;
        audio_trigger  = 1'b1;
        start_in       = 1'b1;
        abort_in       = 1'b0;
        audio_in       = 16'sd0;
        delay_length   = 8'd2;
        record_done_in = 1'b0;
        repeat (2) @(posedge audio_clk);
        #1;
        check("reset", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        start_in = 1'b0;
        rst_in   = 1'b0;

        foreach (vq[i]) apply(vq[i]);

        // Table ends mid-PING: the first reset edge must silence the speaker.
        rst_in = 1'b1;
        @(posedge audio_clk);
        #1;
        check("rst_mid_ping", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        start_in = 1'b1;
        @(posedge audio_clk);
        #1;
        check("rst_over_start", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        start_in = 1'b0;
        rst_in   = 1'b0;
        @(posedge audio_clk);
        #1;

        // Exactly one single-cycle pulse per RECORD entry (rows a, c, d).
        tests++;
        if (rs_pulses !== 3) begin
            fails++;
            $display("FAIL rs_pulse_count: got %0d, expected 3", rs_pulses);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
